// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: memop encodings,
// arbiter state type, default RAM word-address width and the legality check.
package mem_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    // Load memop encodings (d_memop[2:0] when d_we = 0)
    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    // Store memop encodings (d_memop[1:0] when d_we = 1)
    localparam logic [1:0] STOP_SB = 2'b00;
    localparam logic [1:0] STOP_SH = 2'b01;
    localparam logic [1:0] STOP_SW = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } arb_state_e;

    // True when the data request cannot be served: unknown memop or an
    // address not aligned to the access size.
    function automatic logic memop_illegal(input logic       we,
                                           input logic [2:0] memop,
                                           input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (memop[1:0])
                STOP_SB: bad = 1'b0;
                STOP_SH: bad = off[0];
                STOP_SW: bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (memop)
                MEMOP_LB, MEMOP_LBU: bad = 1'b0;
                MEMOP_LH, MEMOP_LHU: bad = off[0];
                MEMOP_LW:            bad = (off != 2'b00);
                default:             bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane handling: extracts and extends load data from a RAM
// word, and merges right-aligned store data into the addressed lanes.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes out of the read word
    always_comb begin
        byte_s = 8'h00;
        case (byte_off)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (byte_off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign- or zero-extend the selected lane according to the load type
    always_comb begin
        load_data = 32'h0000_0000;
        case (memop)
            MEMOP_LB:  load_data = {{24{byte_s[7]}}, byte_s};
            MEMOP_LH:  load_data = {{16{half_s[15]}}, half_s};
            MEMOP_LW:  load_data = rdata;
            MEMOP_LBU: load_data = {24'h00_0000, byte_s};
            MEMOP_LHU: load_data = {16'h0000, half_s};
            default:   load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lanes of the old word with the store data
    always_comb begin
        merged = rdata;
        case (memop[1:0])
            STOP_SB: begin
                case (byte_off)
                    2'b00:   merged[7:0]   = wdata[7:0];
                    2'b01:   merged[15:8]  = wdata[7:0];
                    2'b10:   merged[23:16] = wdata[7:0];
                    2'b11:   merged[31:24] = wdata[7:0];
                    default: merged        = rdata;
                endcase
            end
            STOP_SH: begin
                if (byte_off[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            STOP_SW: merged = wdata;
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port word RAM.
// Grants are combinational in the request cycle; read data returns one
// cycle later. Sub-word stores are done as read-modify-write.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_memop,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_e        state_r, state_nxt_s;
    logic              last_d_r, last_d_nxt_s;      // 1: data port won the last grant
    logic              if_pend_r, if_pend_nxt_s;    // fetch read returns this cycle
    logic              d_ld_pend_r, d_ld_pend_nxt_s;// load read returns this cycle
    logic              d_st_done_r, d_st_done_nxt_s;// store completes this cycle
    logic              d_cap_s;
    logic [2:0]        d_memop_r;
    logic [1:0]        d_off_r;
    logic [31:0]       d_wdata_r;
    logic [ADDR_W-1:0] rmw_addr_r;
    logic              d_bad_s;
    logic [ADDR_W-1:0] d_word_s;
    logic [ADDR_W-1:0] if_word_s;
    logic [31:0]       load_fmt_s;
    logic [31:0]       merged_s;
    logic              unused_s;

    assign d_word_s  = d_addr[ADDR_W+1:2];
    assign if_word_s = if_addr[ADDR_W+1:2];
    assign d_bad_s   = memop_illegal(d_we, d_memop, d_addr[1:0]);
    assign unused_s  = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    mem_lane_fmt u_lane_fmt (
        .memop     (d_memop_r),
        .byte_off  (d_off_r),
        .rdata     (mem_rdata),
        .wdata     (d_wdata_r),
        .load_data (load_fmt_s),
        .merged    (merged_s)
    );

    // State, round-robin pointer, pending responses and captured data request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_d_r    <= 1'b0;
            if_pend_r   <= 1'b0;
            d_ld_pend_r <= 1'b0;
            d_st_done_r <= 1'b0;
            d_memop_r   <= 3'b000;
            d_off_r     <= 2'b00;
            d_wdata_r   <= 32'h0000_0000;
            rmw_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            last_d_r    <= last_d_nxt_s;
            if_pend_r   <= if_pend_nxt_s;
            d_ld_pend_r <= d_ld_pend_nxt_s;
            d_st_done_r <= d_st_done_nxt_s;
            if (d_cap_s) begin
                d_memop_r  <= d_memop;
                d_off_r    <= d_addr[1:0];
                d_wdata_r  <= d_wdata;
                rmw_addr_r <= d_word_s;
            end else begin
                d_memop_r  <= d_memop_r;
                d_off_r    <= d_off_r;
                d_wdata_r  <= d_wdata_r;
                rmw_addr_r <= rmw_addr_r;
            end
        end
    end

    // Arbitration, RAM control, responses and next-state; all quiet in reset
    always_comb begin
        state_nxt_s     = state_r;
        last_d_nxt_s    = last_d_r;
        if_pend_nxt_s   = 1'b0;
        d_ld_pend_nxt_s = 1'b0;
        d_st_done_nxt_s = 1'b0;
        d_cap_s         = 1'b0;
        if_gnt          = 1'b0;
        if_rvalid       = 1'b0;
        if_rdata        = 32'h0000_0000;
        d_gnt           = 1'b0;
        d_rvalid        = 1'b0;
        d_rdata         = 32'h0000_0000;
        d_err           = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = {ADDR_W{1'b0}};
        mem_wdata       = 32'h0000_0000;

        if (rst) begin
            state_nxt_s  = ST_IDLE;
            last_d_nxt_s = 1'b0;
        end else begin
            // Responses for accesses granted last cycle
            if (if_pend_r) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b0;
            end
            if (d_ld_pend_r) begin
                d_rvalid = 1'b1;
                d_rdata  = load_fmt_s;
            end else if (d_st_done_r) begin
                d_rvalid = 1'b1;
            end else begin
                d_rvalid = 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    d_err = d_req & d_bad_s;
                    if (d_req && !d_bad_s && (!if_req || !last_d_r)) begin
                        d_gnt        = 1'b1;
                        d_cap_s      = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = d_word_s;
                        last_d_nxt_s = 1'b1;
                        if (!d_we) begin
                            d_ld_pend_nxt_s = 1'b1;
                        end else if (d_memop[1:0] == STOP_SW) begin
                            mem_we          = 1'b1;
                            mem_wdata       = d_wdata;
                            d_st_done_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RMW_WR;
                        end
                    end else if (if_req) begin
                        if_gnt        = 1'b1;
                        mem_en        = 1'b1;
                        mem_addr      = if_word_s;
                        last_d_nxt_s  = 1'b0;
                        if_pend_nxt_s = 1'b1;
                    end else begin
                        mem_en = 1'b0;
                    end
                end
                ST_RMW_WR: begin
                    mem_en          = 1'b1;
                    mem_we          = 1'b1;
                    mem_addr        = rmw_addr_r;
                    mem_wdata       = merged_s;
                    d_st_done_nxt_s = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checks
// every output every cycle, and directed sequences pin key values literally.
module tb_mem_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req, d_we;
    logic [31:0]   d_addr, d_wdata;
    logic [2:0]    d_memop;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_memop(d_memop), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h1122_3344;
            1:       return 32'h5566_7788;
            4:       return 32'hCAFE_F00D;
            5:       return 32'h8899_AABB;
            default: return {16'hA5A5, i[15:0]};
        endcase
    endfunction

    // Bytes accessed by a request, 0 for an unknown memop
    function automatic int acc_size(input logic we, input logic [2:0] op);
        if (we) begin
            case (op[1:0])
                2'd0: return 1;
                2'd1: return 2;
                2'd2: return 4;
                default: return 0;
            endcase
        end else begin
            case (op)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] op, input int off);
        logic [31:0] v;
        int sz;
        sz = acc_size(1'b0, op);
        v  = w >> (8 * off);
        if (sz == 4) return w;
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'h0000_FFFF;
            if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [31:0] wd, input int sz, input int off);
        logic [31:0] mask;
        mask = ((sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
        return (w & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    // Environment RAM: one-cycle read latency, write in the enable cycle
    logic [31:0] env_ram [0:1023];
    bit          env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 1024; i++) env_ram[i] <= init_word(i);
            env_init <= 1'b1;
        end else begin
            if (mem_en && mem_we) env_ram[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= env_ram[mem_addr];
        end
    end

    // Reference model state
    logic [31:0] m_ram [0:1023];
    bit          m_init = 1'b0;
    bit          m_last = 1'b0, m_if_resp = 1'b0, m_d_resp = 1'b0, m_wr_pend = 1'b0;
    logic [31:0] m_if_word = 32'h0, m_d_word = 32'h0, m_wr_word = 32'h0;
    int          m_wr_idx = 0;
    bit          n_last = 1'b0, n_if_resp = 1'b0, n_d_resp = 1'b0, n_wr_pend = 1'b0, n_ram_we = 1'b0;
    logic [31:0] n_if_word = 32'h0, n_d_word = 32'h0, n_wr_word = 32'h0, n_ram_word = 32'h0;
    int          n_wr_idx = 0, n_ram_idx = 0;

    // Model: expected outputs for this cycle and next model state, then compare
    always @(negedge clk) begin
        logic        e_if_gnt, e_if_rvalid, e_d_gnt, e_d_rvalid, e_d_err, e_mem_en, e_mem_we;
        logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata, w;
        int          sz, off, idx;
        bit          d_ok, take_d, take_f;
        e_if_gnt = 0; e_if_rvalid = 0; e_d_gnt = 0; e_d_rvalid = 0; e_d_err = 0;
        e_mem_en = 0; e_mem_we = 0; e_if_rdata = 0; e_d_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
        n_if_resp = 0; n_if_word = 0; n_d_resp = 0; n_d_word = 0; n_wr_pend = 0;
        n_wr_idx = 0; n_wr_word = 0; n_ram_we = 0; n_ram_idx = 0; n_ram_word = 0;
        n_last = m_last;
        if (rst) begin
            n_last = 0;
        end else begin
            if (m_if_resp) begin e_if_rvalid = 1; e_if_rdata = m_if_word; end
            if (m_d_resp)  begin e_d_rvalid  = 1; e_d_rdata  = m_d_word;  end
            if (m_wr_pend) begin
                e_mem_en = 1; e_mem_we = 1; e_mem_addr = 32'(m_wr_idx); e_mem_wdata = m_wr_word;
                n_ram_we = 1; n_ram_idx = m_wr_idx; n_ram_word = m_wr_word;
                n_d_resp = 1;
            end else begin
                sz   = acc_size(d_we, d_memop);
                off  = int'(d_addr & 32'h3);
                d_ok = 0;
                if (d_req && sz != 0) d_ok = ((off % sz) == 0);
                if (d_req && !d_ok) e_d_err = 1;
                take_d = d_ok && (!if_req || !m_last);
                take_f = if_req && !take_d;
                if (take_d) begin
                    idx = int'((d_addr >> 2) & 32'h3FF);
                    w   = m_ram[idx];
                    e_d_gnt = 1; e_mem_en = 1; e_mem_addr = 32'(idx); n_last = 1;
                    if (!d_we) begin
                        n_d_resp = 1; n_d_word = load_fmt(w, d_memop, off);
                    end else if (sz == 4) begin
                        e_mem_we = 1; e_mem_wdata = d_wdata;
                        n_ram_we = 1; n_ram_idx = idx; n_ram_word = d_wdata; n_d_resp = 1;
                    end else begin
                        n_wr_pend = 1; n_wr_idx = idx; n_wr_word = merge_word(w, d_wdata, sz, off);
                    end
                end
                if (take_f) begin
                    idx = int'((if_addr >> 2) & 32'h3FF);
                    e_if_gnt = 1; e_mem_en = 1; e_mem_addr = 32'(idx); n_last = 0;
                    n_if_resp = 1; n_if_word = m_ram[idx];
                end
            end
        end
        chk1("cyc_if_gnt", if_gnt, e_if_gnt);
        chk1("cyc_if_rvalid", if_rvalid, e_if_rvalid);
        chk32("cyc_if_rdata", if_rdata, e_if_rdata);
        chk1("cyc_d_gnt", d_gnt, e_d_gnt);
        chk1("cyc_d_rvalid", d_rvalid, e_d_rvalid);
        chk32("cyc_d_rdata", d_rdata, e_d_rdata);
        chk1("cyc_d_err", d_err, e_d_err);
        chk1("cyc_mem_en", mem_en, e_mem_en);
        chk1("cyc_mem_we", mem_we, e_mem_we);
        chk32("cyc_mem_addr", {22'd0, mem_addr}, e_mem_addr);
        chk32("cyc_mem_wdata", mem_wdata, e_mem_wdata);
    end

    // Model: commit next state and model RAM writes
    always @(posedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < 1024; i++) m_ram[i] <= init_word(i);
            m_init <= 1'b1;
        end else if (n_ram_we) begin
            m_ram[n_ram_idx] <= n_ram_word;
        end
        m_last    <= n_last;
        m_if_resp <= n_if_resp; m_if_word <= n_if_word;
        m_d_resp  <= n_d_resp;  m_d_word  <= n_d_word;
        m_wr_pend <= n_wr_pend; m_wr_idx  <= n_wr_idx; m_wr_word <= n_wr_word;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_memop = 0;
    endtask

    // Raise a data request and stop at the falling edge of its grant/error cycle
    task automatic d_go(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        bit hit;
        hit = 0;
        d_req = 1; d_we = we; d_memop = op; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if (d_gnt || d_err) hit = 1;
            else cyc();
        end
        if (!hit) chk1("d_wait_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        // Reset with both requests raised: nothing may be granted
        rst = 1; idle();
        d_req = 1; d_memop = 3'b010; d_addr = 32'h14; if_req = 1;
        cyc(); @(negedge clk);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_if_gnt", if_gnt, 1'b0);
        cyc(); rst = 0; idle();
        cyc();

        // Loads from RAM[5] = 8899AABB
        d_go(1'b0, 3'b000, 32'h15, 32'h0);
        chk1("lb_gnt", d_gnt, 1'b1);
        chk32("lb_addr", {22'd0, mem_addr}, 32'd5);
        cyc(); d_req = 0; @(negedge clk);
        chk1("lb_rvalid", d_rvalid, 1'b1);
        chk32("lb_rdata", d_rdata, 32'hFFFF_FFAA);
        cyc();
        d_go(1'b0, 3'b100, 32'h15, 32'h0);
        cyc(); d_req = 0; @(negedge clk);
        chk32("lbu_rdata", d_rdata, 32'h0000_00AA);
        cyc();
        d_go(1'b0, 3'b001, 32'h16, 32'h0);
        cyc(); d_req = 0; @(negedge clk);
        chk32("lh_rdata", d_rdata, 32'hFFFF_8899);
        cyc();

        // Byte store read-modify-write; fetch must wait through the write cycle
        d_go(1'b1, 3'b000, 32'h17, 32'h12);
        chk1("sb_gnt", d_gnt, 1'b1);
        chk1("sb_read", mem_we, 1'b0);
        cyc(); d_req = 0; if_req = 1; if_addr = 32'h0; @(negedge clk);
        chk1("sb_we", mem_we, 1'b1);
        chk32("sb_wdata", mem_wdata, 32'h1299_AABB);
        chk1("sb_no_gnt", if_gnt, 1'b0);
        cyc(); @(negedge clk);
        chk1("sb_rvalid", d_rvalid, 1'b1);
        chk1("sb_then_fetch", if_gnt, 1'b1);
        cyc(); if_req = 0; @(negedge clk);
        chk32("fetch0_rdata", if_rdata, 32'h1122_3344);
        cyc();

        // Contention: alternate grants, data first (fetch won last)
        d_req = 1; d_we = 0; d_memop = 3'b010; d_addr = 32'h20; if_req = 1; if_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("rr_d_gnt", d_gnt, (k % 2) == 0);
            chk1("rr_if_gnt", if_gnt, (k % 2) == 1);
            cyc();
        end
        idle();
        cyc();

        // Misaligned word load, alone then with a concurrent fetch
        d_go(1'b0, 3'b010, 32'h22, 32'h0);
        chk1("mis_err", d_err, 1'b1);
        chk1("mis_mem_en", mem_en, 1'b0);
        chk1("mis_gnt", d_gnt, 1'b0);
        cyc(); d_req = 0; @(negedge clk);
        chk1("mis_err_pulse", d_err, 1'b0);
        cyc();
        if_req = 1; if_addr = 32'h8;
        d_go(1'b0, 3'b010, 32'h22, 32'h0);
        chk1("mis_f_err", d_err, 1'b1);
        chk1("mis_f_if_gnt", if_gnt, 1'b1);
        cyc(); idle();
        cyc();
        // Illegal memops and misaligned halfword store
        d_go(1'b0, 3'b011, 32'h0, 32'h0);
        chk1("ill_ld_err", d_err, 1'b1);
        cyc(); d_req = 0;
        d_go(1'b1, 3'b001, 32'h11, 32'h0);
        chk1("mis_sh_err", d_err, 1'b1);
        cyc(); d_req = 0;
        d_go(1'b1, 3'b011, 32'h0, 32'h0);
        chk1("ill_st_err", d_err, 1'b1);
        cyc(); d_req = 0;
        cyc();

        // Back-to-back fetches
        if_req = 1; if_addr = 32'h0; @(negedge clk);
        chk1("b2b_gnt0", if_gnt, 1'b1);
        cyc(); if_addr = 32'h4; @(negedge clk);
        chk1("b2b_gnt1", if_gnt, 1'b1);
        chk1("b2b_rv0", if_rvalid, 1'b1);
        chk32("b2b_rd0", if_rdata, 32'h1122_3344);
        cyc(); if_req = 0; @(negedge clk);
        chk1("b2b_rv1", if_rvalid, 1'b1);
        chk32("b2b_rd1", if_rdata, 32'h5566_7788);
        cyc();

        // Reset in the write half of a halfword RMW
        d_go(1'b1, 3'b001, 32'h10, 32'h0000_BEEF);
        chk1("rmw_gnt", d_gnt, 1'b1);
        cyc(); d_req = 0; rst = 1; @(negedge clk);
        chk1("rmw_rst_we", mem_we, 1'b0);
        cyc(); rst = 0; @(negedge clk);
        chk1("rmw_rst_rvalid", d_rvalid, 1'b0);
        chk1("rmw_rst_mem_en", mem_en, 1'b0);
        cyc();
        // Pointer back to data-first; RAM[4] untouched
        if_req = 1; if_addr = 32'h8;
        d_go(1'b0, 3'b010, 32'h10, 32'h0);
        chk1("rr_rst_d_first", d_gnt, 1'b1);
        chk1("rr_rst_if_wait", if_gnt, 1'b0);
        cyc(); d_req = 0; @(negedge clk);
        chk32("rmw_rst_ram", d_rdata, 32'hCAFE_F00D);
        chk1("rr_rst_if_next", if_gnt, 1'b1);
        cyc(); if_req = 0;
        cyc();

        // Word store, halfword load, halfword RMW then read back
        d_go(1'b1, 3'b010, 32'h24, 32'h0102_0304);
        chk1("sw_we", mem_we, 1'b1);
        chk32("sw_wdata", mem_wdata, 32'h0102_0304);
        cyc(); d_req = 0; @(negedge clk);
        chk1("sw_rvalid", d_rvalid, 1'b1);
        cyc();
        d_go(1'b0, 3'b101, 32'h26, 32'h0);
        cyc(); d_req = 0; @(negedge clk);
        chk32("lhu_rdata", d_rdata, 32'h0000_0102);
        cyc();
        d_go(1'b1, 3'b001, 32'h20, 32'hFFFF_7777);
        cyc(); d_req = 0;
        cyc(); cyc();
        d_go(1'b0, 3'b010, 32'h20, 32'h0);
        cyc(); d_req = 0; @(negedge clk);
        chk32("sh_readback", d_rdata, 32'hA5A5_7777);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
